// File: rtl/beat_timer_pkg.sv
// Shared types and default widths for the beat_timer channel array.
package beat_timer_pkg;

  // Per-channel run state.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  // Default widths: 26 bits covers one second at a 50 MHz clock.
  localparam int DEF_CNT_W  = 26;
  localparam int DEF_BEAT_W = 8;

  // A zero period would never expire; it behaves as a one-cycle period.
  function automatic logic [DEF_CNT_W-1:0] dummy_unused_guard(input logic [DEF_CNT_W-1:0] p);
    return (p == '0) ? DEF_CNT_W'(1) : p;
  endfunction

endpackage

// File: rtl/beat_timer_ch.sv
// One timer channel: IDLE/RUN FSM, cycle counter, and expiry (beat) counter.
module beat_timer_ch
  import beat_timer_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int BEAT_W = DEF_BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              stop,
  input  logic              periodic,
  input  logic [CNT_W-1:0]  period,
  output logic              done,
  output logic              busy,
  output logic [BEAT_W-1:0] beats
);

  ch_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] per_q;
  logic             mode_q;
  logic [CNT_W-1:0] last;

  // Terminal count; per_q is never 0 while running, so this cannot underflow.
  assign last = per_q - CNT_W'(1);

  // Channel FSM: stop beats start, start beats expiry, en gates all counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      per_q  <= '0;
      mode_q <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
      beats  <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else if (start) begin
        per_q  <= (period == '0) ? CNT_W'(1) : period;
        mode_q <= periodic;
        cnt    <= '0;
        beats  <= '0;
        state  <= RUN;
        busy   <= 1'b1;
      end else if (state == RUN && en) begin
        if (cnt == last) begin
          done  <= 1'b1;
          beats <= beats + BEAT_W'(1);
          cnt   <= '0;
          if (!mode_q) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/beat_timer.sv
// Array of NUM_CH independent period timers with per-channel beat counters.
module beat_timer
  import beat_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int BEAT_W = DEF_BEAT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        start,
  input  logic [NUM_CH-1:0]        stop,
  input  logic [NUM_CH-1:0]        periodic,
  input  logic [NUM_CH*CNT_W-1:0]  period,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH*BEAT_W-1:0] beats
);

  // Channels share only clock, reset and the global enable.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    beat_timer_ch #(
      .CNT_W (CNT_W),
      .BEAT_W(BEAT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .start   (start[i]),
      .stop    (stop[i]),
      .periodic(periodic[i]),
      .period  (period[i*CNT_W +: CNT_W]),
      .done    (done[i]),
      .busy    (busy[i]),
      .beats   (beats[i*BEAT_W +: BEAT_W])
    );
  end

endmodule

// File: tb/tb_beat_timer.sv
// Directed plus random checks of beat_timer against a cycle-count reference model.
module tb_beat_timer;
  localparam int NC = 2;
  localparam int CW = 8;
  localparam int BW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [NC-1:0]    start = '0;
  logic [NC-1:0]    stop = '0;
  logic [NC-1:0]    periodic = '0;
  logic [NC*CW-1:0] period = '0;
  logic [NC-1:0]    done;
  logic [NC-1:0]    busy;
  logic [NC*BW-1:0] beats;

  int n_chk = 0;
  int n_fail = 0;

  // Reference: each channel counts enabled cycles since (re)start or last expiry.
  bit m_run[NC];
  int m_per[NC];
  bit m_mode[NC];
  int m_el[NC];
  int m_beats[NC];
  bit m_done[NC];

  beat_timer #(.NUM_CH(NC), .CNT_W(CW), .BEAT_W(BW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
    .periodic(periodic), .period(period), .done(done), .busy(busy), .beats(beats)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_run[c] = 0; m_per[c] = 0; m_mode[c] = 0;
      m_el[c] = 0; m_beats[c] = 0; m_done[c] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < NC; c++) begin
      m_done[c] = 0;
      if (stop[c]) begin
        m_run[c] = 0;
        m_el[c] = 0;
      end else if (start[c]) begin
        m_run[c] = 1;
        m_per[c] = (period[c*CW +: CW] == 0) ? 1 : int'(period[c*CW +: CW]);
        m_mode[c] = periodic[c];
        m_el[c] = 0;
        m_beats[c] = 0;
      end else if (m_run[c] && en) begin
        m_el[c]++;
        if (m_el[c] >= m_per[c]) begin
          m_done[c] = 1;
          m_beats[c] = (m_beats[c] + 1) % (1 << BW);
          m_el[c] = 0;
          if (!m_mode[c]) m_run[c] = 0;
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [NC-1:0]    ed, eb;
    logic [NC*BW-1:0] ebt;
    for (int c = 0; c < NC; c++) begin
      ed[c] = m_done[c];
      eb[c] = m_run[c];
      ebt[c*BW +: BW] = BW'(m_beats[c]);
    end
    check("model_done", 32'(done), 32'(ed));
    check("model_busy", 32'(busy), 32'(eb));
    check("model_beats", 32'(beats), 32'(ebt));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic set_per(input int c, input int p);
    period[c*CW +: CW] = CW'(p);
  endtask

  initial begin
    model_reset();
    #2;
    check("reset_done", 32'(done), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_beats", 32'(beats), 0);
    @(negedge clk);
    rst = 1'b1;

    // One-shot, P=5 on channel 0.
    en = 1; set_per(0, 5); periodic[0] = 0; start[0] = 1;
    step();
    start[0] = 0;
    for (int k = 1; k <= 7; k++) begin
      step();
      check("oneshot_done", 32'(done[0]), 32'(k == 5));
    end
    check("oneshot_busy", 32'(busy[0]), 0);
    check("oneshot_beats", 32'(beats[BW-1:0]), 1);

    // Periodic, P=3 on channel 1, 12 cycles.
    set_per(1, 3); periodic[1] = 1; start[1] = 1;
    step();
    start[1] = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("periodic_done", 32'(done[1]), 32'(k % 3 == 0));
      check("periodic_busy", 32'(busy[1]), 1);
    end
    check("periodic_beats", 32'(beats[2*BW-1:BW]), 4);
    stop[1] = 1; step(); stop[1] = 0;

    // Pause: P=4, en low for cycles 3..5, expiry moves to cycle 7.
    set_per(0, 4); periodic[0] = 0; start[0] = 1;
    step();
    start[0] = 0;
    for (int k = 1; k <= 9; k++) begin
      en = !(k >= 3 && k <= 5);
      step();
      check("pause_done", 32'(done[0]), 32'(k == 7));
    end
    en = 1;

    // Start together with stop: stop wins.
    set_per(0, 2); start[0] = 1; stop[0] = 1;
    step();
    start[0] = 0; stop[0] = 0;
    check("startstop_busy", 32'(busy[0]), 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("startstop_done", 32'(done[0]), 0);
    end

    // Restart exactly at terminal count: no pulse, count restarts from 0.
    set_per(0, 4); periodic[0] = 1; start[0] = 1;
    step();
    start[0] = 0;
    for (int k = 1; k <= 9; k++) begin
      start[0] = (k == 4);
      step();
      check("restart_done", 32'(done[0]), 32'(k == 8));
    end
    start[0] = 0;
    check("restart_beats", 32'(beats[BW-1:0]), 1);
    stop[0] = 1; step(); stop[0] = 0;

    // P=0 periodic: pulse every cycle, beats wraps after 16 expiries.
    set_per(1, 0); periodic[1] = 1; start[1] = 1;
    step();
    start[1] = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      check("p0_done", 32'(done[1]), 1);
    end
    check("wrap_beats", 32'(beats[2*BW-1:BW]), 0);
    stop[1] = 1; step(); stop[1] = 0;
    check("stop_keeps_beats", 32'(beats[2*BW-1:BW]), 0);

    // Reset mid-count discards the run.
    set_per(0, 5); periodic[0] = 0; start[0] = 1;
    step();
    start[0] = 0;
    step(); step();
    #2;
    rst = 0;
    #1;
    model_reset();
    check("midreset_done", 32'(done), 0);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_beats", 32'(beats), 0);
    @(negedge clk);
    rst = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("postreset_done", 32'(done), 0);
    end

    // Random traffic on both channels.
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 9) < 8);
      for (int c = 0; c < NC; c++) begin
        start[c] = ($urandom_range(0, 15) == 0);
        stop[c] = ($urandom_range(0, 39) == 0);
        periodic[c] = $urandom_range(0, 1);
        set_per(c, $urandom_range(0, 6));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
